uart_pixel_streamer: RTL
========================

# uart_pixel_streamer

Parametrised pixel-to-UART streaming engine for the image-processing pipelines. It accepts filtered pixels of configurable width over a valid/ready handshake and buffers them in an internal FIFO. Each pixel is serialised MSB-byte-first onto an integrated 8N1 UART transmitter, with optional start-of-frame and end-of-frame marker bytes. It sits between any filter stage and the board UART pin, so upstream stages no longer have to pace themselves on transmitter-busy edges.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- UART_BPS, 115200, baud rate; CLKS_PER_BIT = CLK_FREQ/UART_BPS (integer division)
- PIX_W, 8, pixel width in bits; multiple of 8, range 8..32; NB = PIX_W/8 bytes per pixel
- FIFO_DEPTH, 16, pixel FIFO entries; power of 2, at least 2
- HDR_EN, 1, 1 = emit SOF/EOF marker bytes, 0 = raw pixel bytes only
- SOF_BYTE, 8'hA5, marker byte sent before the first pixel of a frame
- EOF_BYTE, 8'h5A, marker byte sent after the pixel flagged last
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel offered
- pix_ready  out  1  FIFO can accept; equals not-full, derived from registered count
- pix_data  in  PIX_W  pixel value
- pix_last  in  1  marks last pixel of frame; qualified by pix_valid
- uart_txd  out  1  serial line, idle high
- tx_busy  out  1  high while FIFO non-empty, framer not IDLE, or a byte is on the line
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- Push occurs on a rising edge with pix_valid and pix_ready both high. The entry stored is {pix_last, pix_data}.
- Pop occurs when the framer fetches the next pixel. Simultaneous push and pop leave fifo_level unchanged.
- When the FIFO is full, pix_ready is 0 and there is no push. A pop while full raises pix_ready on the next cycle.
- Framer FSM states:
  - IDLE: on FIFO non-empty, go to SOF if HDR_EN=1, else go to DATA.
  - SOF: send SOF_BYTE, then go to DATA.
  - DATA: pop one pixel and send its NB bytes, data[PIX_W-1:PIX_W-8] first.
    - After the last byte, if the entry's last flag is 0, fetch the next pixel. If the FIFO is empty, wait in DATA.
    - If the last flag is 1, go to EOF when HDR_EN=1, else go to IDLE and pulse frame_done.
  - EOF: send EOF_BYTE, go to IDLE, pulse frame_done.
- With HDR_EN=1, a frame is therefore SOF, then the pixel bytes, then EOF. The next non-empty FIFO starts a new SOF.
- TX FSM states: TX_IDLE, START, BITS, STOP.
  - Each state or bit lasts exactly CLKS_PER_BIT cycles.
  - BITS sends LSB first; STOP drives 1.
- A byte pending at the end of STOP enters START on the next cycle, so there is no idle gap between bytes of one frame.
- Reset values: uart_txd=1, pix_ready=1 (FIFO empty), tx_busy=0, fifo_level=0, frame_done=0, both FSMs idle.
- Asserting rst_n low at any time, including mid-byte:
  - uart_txd returns to 1 immediately and the FIFO is flushed.
  - The partial frame is discarded; no EOF byte and no frame_done.

## Timing
- Latency: a pixel accepted on edge T into an empty FIFO with the framer IDLE puts the start bit on uart_txd at edge T+3. That start bit belongs to SOF when HDR_EN=1, otherwise to the first pixel byte.
- Byte period: exactly 10*CLKS_PER_BIT cycles.
- Frame duration with continuous supply: (NB*pixels + 2*HDR_EN)*10*CLKS_PER_BIT cycles.
- frame_done is high for the single cycle after the final stop bit completes.
- tx_busy falls in the same cycle frame_done rises, provided the FIFO is empty.
- fifo_level updates on the edge after the push or pop.
- pix_ready changes only on clock edges; there is no combinational path from pix_valid.

## Test plan
- PIX_W=8, HDR_EN=0, CLK_FREQ=1000000, UART_BPS=100000:
  - Stimulus: push 8'h3C with last=1.
  - Required: start bit at T+3; line bits 0,0,0,1,1,1,1,0,0,1 at 10 cycles each; frame_done 100 cycles after the start bit begins.
- PIX_W=16, HDR_EN=1, same clock and baud:
  - Stimulus: push 16'h1234, 16'hABCD, then 16'h00FF with last=1.
  - Required: byte stream A5 12 34 AB CD 00 FF 5A, back-to-back with no idle cycles, then a single frame_done pulse.
- Backpressure, FIFO_DEPTH=4:
  - Stimulus: hold pix_valid high with 6 pixels.
  - Required: pix_ready drops when fifo_level=4 and rises again after the first pop; all 6 pixels are transmitted in order with none lost or duplicated.
- Starvation:
  - Stimulus: push 2 pixels without last, wait 500 cycles, then push 1 pixel with last.
  - Required: line stays high during the gap; no second SOF; a single EOF follows the third pixel.
- Reset mid-operation:
  - Stimulus: assert rst_n low during BITS of the second byte.
  - Required: uart_txd=1 asynchronously, fifo_level=0, no frame_done.
  - Then: a new pixel after release restarts with SOF at T+3.
- Two frames back-to-back:
  - Stimulus: frame A with last on pixel 1, frame B queued behind it.
  - Required: EOF of A is immediately followed by SOF of B; two frame_done pulses.

Source files
------------

// File: rtl/uart_pixel_streamer.sv
// Pixel FIFO feeding a byte framer (optional SOF/EOF markers) and an 8N1 UART transmitter.
// Pixels are sent MSB byte first. A single-byte pending slot lets the next byte queue during the current one.
module uart_pixel_streamer #(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          UART_BPS   = 115200,
  parameter int          PIX_W      = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter int          HDR_EN     = 1,
  parameter logic [7:0]  SOF_BYTE   = 8'hA5,
  parameter logic [7:0]  EOF_BYTE   = 8'h5A
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [PIX_W-1:0]              pix_data,
  input  logic                          pix_last,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic [3:0]                    dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / UART_BPS;
  localparam int NB           = PIX_W / 8;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]    NB_M1    = 3'(NB - 1);

  typedef enum logic [1:0] {FR_IDLE, FR_SOF, FR_DATA, FR_EOF} fr_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_BITS, TX_STOP} tx_state_t;

  // Pixel FIFO; each entry is {last, data}
  logic [PIX_W:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push, pop, fifo_empty;
  logic [PIX_W:0]  head;

  assign pix_ready  = (count_q != FULL_LVL);
  assign push       = pix_valid && pix_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign fifo_level = count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pix_last, pix_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Framer state and pending-byte slot
  fr_state_t        fr_state_q, fr_state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             last_q, last_d, have_q, have_d;
  logic [2:0]       rem_q, rem_d;
  logic             pend_valid_q, pend_valid_d, pend_end_q, pend_end_d;
  logic [7:0]       pend_byte_q, pend_byte_d;
  logic             fr_load, fr_end, pixel_done, end_flag, tx_take;
  logic [7:0]       fr_byte;

  always_comb begin
    fr_state_d = fr_state_q;
    pix_d      = pix_q;
    last_d     = last_q;
    have_d     = have_q;
    rem_d      = rem_q;
    fr_load    = 1'b0;
    fr_end     = 1'b0;
    fr_byte    = 8'h00;
    pop        = 1'b0;
    pixel_done = 1'b0;
    end_flag   = 1'b0;
    case (fr_state_q)
      FR_IDLE: begin
        if (!fifo_empty) fr_state_d = (HDR_EN != 0) ? FR_SOF : FR_DATA;
      end
      FR_SOF: begin
        if (!pend_valid_q) begin
          fr_load    = 1'b1;
          fr_byte    = SOF_BYTE;
          fr_state_d = FR_DATA;
        end
      end
      FR_DATA: begin
        if (!pend_valid_q) begin
          if (have_q) begin
            fr_load = 1'b1;
            fr_byte = pix_q[PIX_W-1 -: 8];
            pix_d   = pix_q << 8;
            rem_d   = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
              have_d     = 1'b0;
              pixel_done = 1'b1;
              end_flag   = last_q;
            end
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            fr_load = 1'b1;
            fr_byte = head[PIX_W-1 -: 8];
            pix_d   = head[PIX_W-1:0] << 8;
            last_d  = head[PIX_W];
            if (NB == 1) begin
              pixel_done = 1'b1;
              end_flag   = head[PIX_W];
            end else begin
              have_d = 1'b1;
              rem_d  = NB_M1;
            end
          end
          // Without markers the final pixel byte itself carries the end-of-frame tag
          if (pixel_done && end_flag) begin
            if (HDR_EN != 0) begin
              fr_state_d = FR_EOF;
            end else begin
              fr_state_d = FR_IDLE;
              fr_end     = 1'b1;
            end
          end
        end
      end
      FR_EOF: begin
        if (!pend_valid_q) begin
          fr_load    = 1'b1;
          fr_byte    = EOF_BYTE;
          fr_end     = 1'b1;
          fr_state_d = FR_IDLE;
        end
      end
      default: fr_state_d = FR_IDLE;
    endcase
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_byte_d  = pend_byte_q;
    pend_end_d   = pend_end_q;
    if (tx_take) pend_valid_d = 1'b0;
    if (fr_load) begin
      pend_valid_d = 1'b1;
      pend_byte_d  = fr_byte;
      pend_end_d   = fr_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_state_q   <= FR_IDLE;
      pix_q        <= '0;
      last_q       <= 1'b0;
      have_q       <= 1'b0;
      rem_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
      pend_end_q   <= 1'b0;
    end else begin
      fr_state_q   <= fr_state_d;
      pix_q        <= pix_d;
      last_q       <= last_d;
      have_q       <= have_d;
      rem_q        <= rem_d;
      pend_valid_q <= pend_valid_d;
      pend_byte_q  <= pend_byte_d;
      pend_end_q   <= pend_end_d;
    end
  end

  // UART transmitter; frame_done fires when a byte tagged as frame end finishes its stop bit
  tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d, end_q, end_d, done_q, done_d;

  always_comb begin
    tx_state_d = tx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    end_d      = end_q;
    done_d     = 1'b0;
    tx_take    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (pend_valid_q) begin
          tx_take    = 1'b1;
          shift_d    = pend_byte_q;
          end_d      = pend_end_q;
          cnt_d      = '0;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d      = '0;
          bit_d      = 3'd0;
          txd_d      = shift_q[0];
          tx_state_d = TX_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_BITS: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          done_d = end_q;
          if (pend_valid_q) begin
            tx_take    = 1'b1;
            shift_d    = pend_byte_q;
            end_d      = pend_end_q;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            txd_d      = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      end_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      end_q      <= end_d;
      done_q     <= done_d;
    end
  end

  assign uart_txd   = txd_q;
  assign frame_done = done_q;
  assign tx_busy    = !fifo_empty || (fr_state_q != FR_IDLE) || pend_valid_q || (tx_state_q != TX_IDLE);
  assign dbg_state  = {fr_state_q, tx_state_q};

endmodule
